binning_nxn: RTL and testbench

- Parametrised successor of the fixed 4x4 binary binning stage.
- Downsamples a 1-bit mask stream (hcount/vcount raster) into 2^BIN_LOG2 x 2^BIN_LOG2 bins.
- Emits one thresholded bit per bin, using a runtime threshold.
- Sits between the pixel-mask stage and the downsampled-frame consumer. Adds pixel qualification, blanking rejection and correct last-bin-of-line emission.

---
 rtl/binning_nxn.sv | 102 ++++++++++
 tb/tb_binning_nxn.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binning_nxn.sv
// Bins a 1-bit raster mask into 2^BIN_LOG2 square bins and emits one thresholded bit per bin.
// Define BINNING_COUNT_OUT_EN to also expose the registered per-bin popcount on count_out.
module binning_nxn #(
    parameter  int H_RES    = 1280,
    parameter  int V_RES    = 720,
    parameter  int H_BITS   = 11,
    parameter  int V_BITS   = 10,
    parameter  int BIN_LOG2 = 2,
    localparam int CW       = 2 * BIN_LOG2 + 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [H_BITS-1:0]          hcount_in,
    input  logic [V_BITS-1:0]          vcount_in,
    input  logic                       pixel_valid_in,
    input  logic                       pixel_bit,
    input  logic [CW-1:0]              thresh_in,
    output logic                       valid_out,
    output logic [H_BITS-BIN_LOG2-1:0] hcount_out,
    output logic [V_BITS-BIN_LOG2-1:0] vcount_out,
`ifdef BINNING_COUNT_OUT_EN
    output logic [CW-1:0]              count_out,
`endif
    output logic                       binned_output
);

    localparam int NCOL = H_RES >> BIN_LOG2;
    localparam int CIW  = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [BIN_LOG2-1:0] SUB_MAX = '1;
    localparam logic [H_BITS:0]     H_LIM   = (H_BITS + 1)'(H_RES);
    localparam logic [V_BITS:0]     V_LIM   = (V_BITS + 1)'(V_RES);

    generate
        if (BIN_LOG2 < 1 || BIN_LOG2 > 4) begin : g_bad_bin_log2
            $error("binning_nxn: BIN_LOG2 must be in 1..4");
        end
        if ((H_RES % (1 << BIN_LOG2)) != 0 || (V_RES % (1 << BIN_LOG2)) != 0) begin : g_bad_res
            $error("binning_nxn: H_RES and V_RES must be multiples of the bin edge");
        end
    endgenerate

    // One partial count per bin column; a bin row reuses the same entries.
    logic [CW-1:0] r_acc     [0:NCOL-1];
    // Set when a column's bin was started after reset, so stale counts never emit.
    logic          r_started [0:NCOL-1];

    logic [BIN_LOG2-1:0]        w_hl;
    logic [BIN_LOG2-1:0]        w_r;
    logic [H_BITS-BIN_LOG2-1:0] w_col;
    logic [CIW-1:0]             w_idx;
    logic                       w_accept;
    logic                       w_first;
    logic                       w_last;
    logic [CW-1:0]              w_bit_ext;
    logic [CW-1:0]              w_total;

    assign w_hl      = hcount_in[BIN_LOG2-1:0];
    assign w_r       = vcount_in[BIN_LOG2-1:0];
    assign w_col     = hcount_in[H_BITS-1:BIN_LOG2];
    assign w_idx     = w_col[CIW-1:0];
    assign w_accept  = pixel_valid_in && ({1'b0, hcount_in} < H_LIM) && ({1'b0, vcount_in} < V_LIM);
    assign w_first   = (w_r == '0) && (w_hl == '0);
    assign w_last    = (w_r == SUB_MAX) && (w_hl == SUB_MAX);
    assign w_bit_ext = {{(CW-1){1'b0}}, pixel_bit};
    assign w_total   = r_acc[w_idx] + w_bit_ext;

    always_ff @(posedge clk_in) begin
        if (w_accept && !w_last) begin
            r_acc[w_idx] <= w_first ? w_bit_ext : w_total;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_out     <= 1'b0;
            binned_output <= 1'b0;
            hcount_out    <= '0;
            vcount_out    <= '0;
`ifdef BINNING_COUNT_OUT_EN
            count_out     <= '0;
`endif
            for (int i = 0; i < NCOL; i++) begin
                r_started[i] <= 1'b0;
            end
        end else begin
            valid_out <= 1'b0;
            if (w_accept && w_first) begin
                r_started[w_idx] <= 1'b1;
            end
            if (w_accept && w_last && r_started[w_idx]) begin
                valid_out     <= 1'b1;
                hcount_out    <= w_col;
                vcount_out    <= vcount_in[V_BITS-1:BIN_LOG2];
                binned_output <= (w_total >= thresh_in);
`ifdef BINNING_COUNT_OUT_EN
                count_out     <= w_total;
`endif
            end
        end
    end

endmodule

// File: tb/tb_binning_nxn.sv
// Randomized frame-level bench for binning_nxn on a reduced 64x16 raster with blanking.
module tb_binning_nxn;
  localparam int HR = 64;
  localparam int VR = 16;
  localparam int HB = 7;
  localparam int VB = 5;
  localparam int BL = 2;
  localparam int CW = 2 * BL + 1;
  localparam int N = 1 << BL;
  localparam int HT = 72;
  localparam int VT = 18;
  localparam int NBX = HR / N;
  localparam int NBY = VR / N;
  localparam int OHB = HB - BL;
  localparam int OVB = VB - BL;

  typedef struct packed {
    int unsigned    cyc;
    logic [OHB-1:0] h;
    logic [OVB-1:0] v;
    logic           b;
    logic [CW-1:0]  cnt;
  } pulse_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n_in;
  logic [HB-1:0]  hcount_in;
  logic [VB-1:0]  vcount_in;
  logic           pixel_valid_in;
  logic           pixel_bit;
  logic [CW-1:0]  thresh_in;
  logic           valid_out;
  logic [OHB-1:0] hcount_out;
  logic [OVB-1:0] vcount_out;
  logic           binned_output;
`ifdef BINNING_COUNT_OUT_EN
  logic [CW-1:0]  count_out;
`endif

  binning_nxn #(
    .H_RES(HR), .V_RES(VR), .H_BITS(HB), .V_BITS(VB), .BIN_LOG2(BL)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .pixel_valid_in(pixel_valid_in),
    .pixel_bit(pixel_bit),
    .thresh_in(thresh_in),
    .valid_out(valid_out),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
`ifdef BINNING_COUNT_OUT_EN
    .count_out(count_out),
`endif
    .binned_output(binned_output)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame image and per-pixel drive cycle
  logic          f_pix [VT][HT];
  logic          f_val [VT][HT];
  logic [CW-1:0] f_thr [VT][HT];
  int unsigned   f_cyc [VT][HT];

  pulse_t obs_q[$];
  pulse_t exp_q[$];

  logic           snap_valid, snap_b;
  logic [OHB-1:0] snap_h;
  logic [OVB-1:0] snap_v;
  logic [CW-1:0]  snap_cnt;

  function automatic logic [CW-1:0] obs_cnt();
`ifdef BINNING_COUNT_OUT_EN
    return count_out;
`else
    return '0;
`endif
  endfunction

  function automatic string fmt(pulse_t p);
    return $sformatf("cyc=%0d h=%0d v=%0d b=%0d cnt=%0d", p.cyc, p.h, p.v, p.b, p.cnt);
  endfunction

  always @(negedge clk) begin
    if (valid_out === 1'b1) obs_q.push_back(pulse_t'{cyc, hcount_out, vcount_out, binned_output, obs_cnt()});
  end

  // driver tasks
  task automatic clear_frame(input logic pbit, input logic pval);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (v < VR && h < HR) begin
          f_pix[v][h] = pbit;
          f_val[v][h] = pval;
        end else begin
          f_pix[v][h] = 1'b1;
          f_val[v][h] = 1'($urandom_range(0, 1));
        end
        f_thr[v][h] = CW'($urandom_range(0, 31));
      end
    end
  endtask

  task automatic set_emit_thr(input int lo, input int hi);
    for (int by = 0; by < NBY; by++)
      for (int bx = 0; bx < NBX; bx++)
        f_thr[by*N+N-1][bx*N+N-1] = CW'($urandom_range(lo, hi));
  endtask

  task automatic fill_bin(input int bx, input int by, input int n);
    int placed = 0;
    int k;
    for (int i = 0; i < N * N; i++) f_pix[by*N + i/N][bx*N + i%N] = 1'b0;
    while (placed < n) begin
      k = $urandom_range(0, N * N - 1);
      if (f_pix[by*N + k/N][bx*N + k%N] == 1'b0) begin
        f_pix[by*N + k/N][bx*N + k%N] = 1'b1;
        placed++;
      end
    end
  endtask

  task automatic run_frame(input int rv, input int rh);
    logic was_rst = 1'b0;
    obs_q.delete();
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        @(negedge clk);
        if (was_rst) begin
          snap_valid = valid_out;
          snap_b = binned_output;
          snap_h = hcount_out;
          snap_v = vcount_out;
          snap_cnt = obs_cnt();
        end
        f_cyc[v][h] = cyc;
        rst_n_in = !(v == rv && h == rh);
        was_rst = !rst_n_in;
        hcount_in = HB'(h);
        vcount_in = VB'(v);
        pixel_valid_in = f_val[v][h];
        pixel_bit = f_pix[v][h];
        thresh_in = f_thr[v][h];
      end
    end
    @(negedge clk);
    pixel_valid_in = 1'b0;
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // reference model: whole-bin popcount from the frame image
  task automatic build_expected(input int rv, input int rh);
    int cnt;
    int sv, sh, ev, eh;
    logic started;
    exp_q.delete();
    for (int by = 0; by < NBY; by++) begin
      for (int bx = 0; bx < NBX; bx++) begin
        sv = by * N; sh = bx * N; ev = sv + N - 1; eh = sh + N - 1;
        started = f_val[sv][sh] && (rv < 0 || (sv * HT + sh) > (rv * HT + rh));
        if (started && f_val[ev][eh]) begin
          cnt = 0;
          for (int dy = 0; dy < N; dy++)
            for (int dx = 0; dx < N; dx++)
              if (f_val[sv+dy][sh+dx]) cnt += int'(f_pix[sv+dy][sh+dx]);
`ifdef BINNING_COUNT_OUT_EN
          exp_q.push_back(pulse_t'{f_cyc[ev][eh] + 1, OHB'(bx), OVB'(by), cnt >= int'(f_thr[ev][eh]), CW'(cnt)});
`else
          exp_q.push_back(pulse_t'{f_cyc[ev][eh] + 1, OHB'(bx), OVB'(by), cnt >= int'(f_thr[ev][eh]), CW'(0)});
`endif
        end
      end
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n_in = 1'b0; pixel_valid_in = 1'b0; pixel_bit = 1'b0;
    hcount_in = '0; vcount_in = '0; thresh_in = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({valid_out, binned_output, hcount_out, vcount_out, obs_cnt()} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b b=%b h=%0d v=%0d cnt=%0d, want all 0",
               valid_out, binned_output, hcount_out, vcount_out, obs_cnt());
    end
    rst_n_in = 1'b1;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_valid: got %b want 0", valid_out);
    end
  endtask

  task automatic test_all_ones();
    clear_frame(1'b1, 1'b1);
    set_emit_thr(8, 8);
    run_frame(-1, -1);
    build_expected(-1, -1);
    tests_run++;
    if (obs_q.size() != NBX * NBY) begin
      tests_failed++;
      $display("FAIL all_ones pulse_count: got %0d want %0d", obs_q.size(), NBX * NBY);
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL all_ones pulse %0d: got none want %s", i, fmt(exp_q[i]));
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL all_ones pulse %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    if (obs_q.size() > NBX) begin
      tests_run++;
      if (obs_q[0].h !== 0 || obs_q[0].v !== 0 || obs_q[0].b !== 1'b1 || obs_q[0].cyc !== f_cyc[3][3] + 1) begin
        tests_failed++;
        $display("FAIL all_ones first_bin: got %s want h=0 v=0 b=1 cyc=%0d", fmt(obs_q[0]), f_cyc[3][3] + 1);
      end
      tests_run++;
      if (obs_q[NBX-1].h !== OHB'(NBX - 1) || obs_q[NBX-1].v !== 0 || obs_q[NBX-1].cyc !== f_cyc[3][HR-1] + 1
          || obs_q[NBX-1].cyc >= f_cyc[4][0]) begin
        tests_failed++;
        $display("FAIL all_ones last_column: got %s want h=%0d v=0 cyc=%0d (< %0d)",
                 fmt(obs_q[NBX-1]), NBX - 1, f_cyc[3][HR-1] + 1, f_cyc[4][0]);
      end
`ifdef BINNING_COUNT_OUT_EN
      tests_run++;
      if (obs_q[0].cnt !== CW'(16)) begin
        tests_failed++;
        $display("FAIL all_ones first_count: got %0d want 16", obs_q[0].cnt);
      end
`endif
    end
  endtask

  task automatic test_threshold();
    logic exp_b [6];
    int   exp_c [6];
    exp_b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_c = '{8, 7, 0, 16, 16, 1};
    clear_frame(1'b0, 1'b1);
    for (int by = 0; by < NBY; by++)
      for (int bx = 0; bx < NBX; bx++) fill_bin(bx, by, $urandom_range(0, 16));
    set_emit_thr(0, 17);
    fill_bin(0, 0, 8);  f_thr[3][3]  = CW'(8);
    fill_bin(1, 0, 7);  f_thr[3][7]  = CW'(8);
    fill_bin(2, 0, 0);  f_thr[3][11] = CW'(0);
    fill_bin(3, 0, 16); f_thr[3][15] = CW'(17);
    fill_bin(4, 0, 16); f_thr[3][19] = CW'(16);
    fill_bin(5, 0, 1);  f_thr[3][23] = CW'(1);
    run_frame(-1, -1);
    build_expected(-1, -1);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL threshold pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL threshold pulse %0d: got none want %s", i, fmt(exp_q[i]));
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL threshold pulse %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i].b !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL threshold edge_bin%0d: got b=%b want %b", i, obs_q[i].b, exp_b[i]);
      end
`ifdef BINNING_COUNT_OUT_EN
      tests_run++;
      if (obs_q[i].cnt !== CW'(exp_c[i])) begin
        tests_failed++;
        $display("FAIL threshold edge_count%0d: got %0d want %0d", i, obs_q[i].cnt, exp_c[i]);
      end
`endif
    end
  endtask

  task automatic test_missing_pixels();
    int idx = NBX + 2;
    int dropped = 0;
    clear_frame(1'b1, 1'b1);
    set_emit_thr(8, 8);
    f_val[4][9] = 1'b0; f_val[5][10] = 1'b0; f_val[6][8] = 1'b0; f_val[6][11] = 1'b0;
    f_val[11][23] = 1'b0;
    run_frame(-1, -1);
    build_expected(-1, -1);
    tests_run++;
    if (obs_q.size() != NBX * NBY - 1) begin
      tests_failed++;
      $display("FAIL missing pulse_count: got %0d want %0d", obs_q.size(), NBX * NBY - 1);
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL missing pulse %0d: got none want %s", i, fmt(exp_q[i]));
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL missing pulse %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    foreach (obs_q[i]) if (obs_q[i].h == 5 && obs_q[i].v == 2) dropped++;
    tests_run++;
    if (dropped != 0) begin
      tests_failed++;
      $display("FAIL missing dropped_bin: got %0d pulses for bin (5,2) want 0", dropped);
    end
    if (obs_q.size() > idx) begin
      tests_run++;
      if (obs_q[idx].h !== 2 || obs_q[idx].v !== 1 || obs_q[idx].b !== 1'b1) begin
        tests_failed++;
        $display("FAIL missing bin_2_1: got %s want h=2 v=1 b=1", fmt(obs_q[idx]));
      end
`ifdef BINNING_COUNT_OUT_EN
      tests_run++;
      if (obs_q[idx].cnt !== CW'(12)) begin
        tests_failed++;
        $display("FAIL missing count_2_1: got %0d want 12", obs_q[idx].cnt);
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    int row0 = 0;
    clear_frame(1'b0, 1'b1);
    for (int v = 0; v < 4; v++) for (int h = 0; h < HR; h++) f_pix[v][h] = 1'b1;
    for (int v = 8; v < VR; v++) for (int h = 0; h < HR; h++) f_pix[v][h] = 1'($urandom_range(0, 1));
    set_emit_thr(1, 17);
    run_frame(2, 5);
    build_expected(2, 5);
    tests_run++;
    if ({snap_valid, snap_b, snap_h, snap_v, snap_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset outputs: got valid=%b b=%b h=%0d v=%0d cnt=%0d, want all 0",
               snap_valid, snap_b, snap_h, snap_v, snap_cnt);
    end
    foreach (obs_q[i]) if (obs_q[i].v == 0) row0++;
    tests_run++;
    if (row0 != 0) begin
      tests_failed++;
      $display("FAIL mid_reset row0_pulses: got %0d want 0", row0);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL mid_reset pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL mid_reset pulse %0d: got none want %s", i, fmt(exp_q[i]));
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL mid_reset pulse %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    if (obs_q.size() > 0) begin
      tests_run++;
      if (obs_q[0].h !== 0 || obs_q[0].v !== 1 || obs_q[0].b !== 1'b0 || obs_q[0].cnt !== '0) begin
        tests_failed++;
        $display("FAIL mid_reset first_clean_bin: got %s want h=0 v=1 b=0 cnt=0", fmt(obs_q[0]));
      end
    end
  endtask

  task automatic test_random(input int frames);
    for (int f = 0; f < frames; f++) begin
      clear_frame(1'b0, 1'b1);
      for (int v = 0; v < VR; v++) begin
        for (int h = 0; h < HR; h++) begin
          f_pix[v][h] = 1'($urandom_range(0, 1));
          f_val[v][h] = ($urandom_range(0, 99) < 85);
          if (v % N == 0 && h % N == 0) f_val[v][h] = 1'b1;
          if (v % N == N - 1 && h % N == N - 1) f_val[v][h] = ($urandom_range(0, 9) != 0);
        end
      end
      set_emit_thr(0, 17);
      run_frame(-1, -1);
      build_expected(-1, -1);
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL random%0d pulse_count: got %0d want %0d", f, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        tests_run++;
        if (i >= obs_q.size()) begin
          tests_failed++;
          $display("FAIL random%0d pulse %0d: got none want %s", f, i, fmt(exp_q[i]));
        end else if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL random%0d pulse %0d: got %s want %s", f, i, fmt(obs_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_threshold();
    test_missing_pixels();
    test_mid_reset();
    test_random(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
